tmu_clip: RTL

TMU_CLIP -- requirements
Module: tmu_clip

---
 rtl/tmu_clip.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/tmu_clip.sv
// tmu_clip: two-stage vertex clipper for the texture-mapping unit.
// Stage S1 applies the screen offsets and the texture out-of-range policy;
// stage S2 clips against the destination resolution and drives the outputs.
// Discarded vertices are tallied in a saturating drop counter.
module tmu_clip #(
   parameter int CW  = 11,
   parameter int TW  = 11,
   parameter int DCW = 16
) (
   input  logic           sys_clk,
   input  logic           sys_rst,

   input  logic [TW-1:0]  src_hres,
   input  logic [TW-1:0]  src_vres,
   input  logic [CW-1:0]  dst_hres,
   input  logic [CW-1:0]  dst_vres,
   input  logic [CW-1:0]  hoffset,
   input  logic [CW-1:0]  voffset,
   input  logic [1:0]     uv_mode,
   input  logic           drop_clr,

   input  logic           pipe_stb_i,
   output logic           pipe_ack_o,
   input  logic [CW-1:0]  P_X,
   input  logic [CW-1:0]  P_Y,
   input  logic [TW-1:0]  P_U,
   input  logic [TW-1:0]  P_V,

   output logic           pipe_stb_o,
   input  logic           pipe_ack_i,
   output logic [CW-1:0]  P_Xf,
   output logic [CW-1:0]  P_Yf,
   output logic [TW-1:0]  P_Uf,
   output logic [TW-1:0]  P_Vf,

   output logic           busy,
   output logic [DCW-1:0] drop_count
);

   // Texture axis policy; returns {drop, mapped coordinate}.
   // Mode 11 falls into the default branch and behaves like discard.
   function automatic logic [TW:0] tex_map(input logic [TW-1:0] p,
                                           input logic [TW-1:0] res,
                                           input logic [1:0]    mode);
      logic          drop;
      logic [TW-1:0] val;
      drop = 1'b0;
      val  = p;
      case (mode)
         2'b01: begin
            if (res == '0)
               drop = 1'b1;
            else if (p >= res)
               val = res - TW'(1);
         end
         2'b10: val = p & (res - TW'(1));
         default: drop = (p >= res);
      endcase
      return {drop, val};
   endfunction

   logic          s1_valid;
   logic          s2_valid;
   logic [CW-1:0] s1_x;
   logic [CW-1:0] s1_y;
   logic [TW-1:0] s1_u;
   logic [TW-1:0] s1_v;

   logic          s1_cap;
   logic          s2_load;
   logic          s1_drop;
   logic          s2_drop;
   logic          cap_drop;
   logic          load_drop;
   logic [TW:0]   u_res;
   logic [TW:0]   v_res;
   logic [1:0]    n_drops;
   logic [DCW:0]  cnt_sum;

   assign s2_load    = s1_valid & (~s2_valid | pipe_ack_i);
   assign pipe_ack_o = ~s1_valid | s2_load;
   assign s1_cap     = pipe_stb_i & pipe_ack_o;

   assign pipe_stb_o = s2_valid;
   assign busy       = s1_valid | s2_valid;

   // Per-axis texture mapping of the incoming vertex
   always_comb begin
      u_res = tex_map(P_U, src_hres, uv_mode);
      v_res = tex_map(P_V, src_vres, uv_mode);
   end

   assign s1_drop   = (P_X < hoffset) | (P_Y < voffset) | u_res[TW] | v_res[TW];
   assign s2_drop   = (s1_x >= dst_hres) | (s1_y >= dst_vres);
   assign cap_drop  = s1_cap & s1_drop;
   assign load_drop = s2_load & s2_drop;

   // Up to two drops per cycle (one per stage), summed with a carry bit for saturation
   always_comb begin
      n_drops = {1'b0, cap_drop} + {1'b0, load_drop};
      cnt_sum = {1'b0, drop_count} + (DCW+1)'(n_drops);
   end

   // Valid flags and drop counter; reset discards in-flight vertices uncounted
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         s1_valid   <= 1'b0;
         s2_valid   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (s1_cap)
            s1_valid <= ~s1_drop;
         else if (s2_load)
            s1_valid <= 1'b0;

         if (s2_load)
            s2_valid <= ~s2_drop;
         else if (pipe_ack_i)
            s2_valid <= 1'b0;

         if (drop_clr)
            drop_count <= '0;
         else if (cnt_sum[DCW])
            drop_count <= '1;
         else
            drop_count <= cnt_sum[DCW-1:0];
      end
   end

   // Stage data registers; contents are only meaningful while the matching valid is set
   always_ff @(posedge sys_clk) begin
      if (s1_cap) begin
         s1_x <= P_X - hoffset;
         s1_y <= P_Y - voffset;
         s1_u <= u_res[TW-1:0];
         s1_v <= v_res[TW-1:0];
      end
      if (s2_load) begin
         P_Xf <= s1_x;
         P_Yf <= s1_y;
         P_Uf <= s1_u;
         P_Vf <= s1_v;
      end
   end

endmodule
